ofs_plat_host_chan_wrr_mux: RTL and testbench

- Parametrised N-port host-channel multiplexer. Several AFU-side request streams share one FIU-side host channel.
- Arbitration is weighted round-robin. Per-port outstanding-request limits apply.
- Each FIU tag is extended with the source port index so that responses route back to the originating port.
- Generalised successor to the fixed CCI-P emulation fan-out: configurable port count, widths, weights and depth. It sits between a single native host channel and the per-group emulated ports.

---
 rtl/ofs_plat_host_chan_wrr_mux.sv | 256 +++++++++++++++++++++++++
 tb/tb_ofs_plat_host_chan_wrr_mux.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_host_chan_wrr_mux.sv
// ofs_plat_host_chan_wrr_mux
//
// Shares one FIU-side host channel among NUM_PORTS AFU-side request streams.
// Requests are picked by a weighted round-robin arbiter and held in a single
// output register. The source port index is prepended to the AFU tag, so a
// response can be routed back to the port that issued the request.
// Each port may have at most MAX_OUTSTANDING requests in flight.
//
// Optional feature: define OFS_PLAT_HOST_CHAN_MUX_STATS_EN to build the
// per-port 32-bit saturating grant counters. When it is not defined,
// stat_grant_cnt is tied to zero.
//
// Ports:
//   clk, reset_n      clock; asynchronous active-low reset
//   port_weight       per-port grants per turn (a weight of 0 counts as 1)
//   afu_req_*         per-port request streams (ready is the one-hot grant)
//   fiu_req_*         registered request to the FIU; tag = {port, afu tag}
//   fiu_rsp_*         FIU responses (no backpressure)
//   afu_rsp_*         registered one-hot response valid, broadcast data/tag
//   rsp_err           sticky flag: a response carried an out-of-range port index
//   stat_grant_cnt    per-port grant counters (zero unless stats are enabled)

module ofs_plat_host_chan_wrr_mux #(
  parameter int NUM_PORTS       = 4,
  parameter int REQ_WIDTH       = 128,
  parameter int RSP_WIDTH       = 512,
  parameter int TAG_WIDTH       = 16,
  parameter int WEIGHT_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 64,
  localparam int PIDX_W         = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] port_weight,
  input  logic [NUM_PORTS-1:0]              afu_req_valid,
  output logic [NUM_PORTS-1:0]              afu_req_ready,
  input  logic [NUM_PORTS*REQ_WIDTH-1:0]    afu_req_data,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]    afu_req_tag,
  output logic                              fiu_req_valid,
  input  logic                              fiu_req_ready,
  output logic [REQ_WIDTH-1:0]              fiu_req_data,
  output logic [TAG_WIDTH+PIDX_W-1:0]       fiu_req_tag,
  input  logic                              fiu_rsp_valid,
  input  logic [RSP_WIDTH-1:0]              fiu_rsp_data,
  input  logic [TAG_WIDTH+PIDX_W-1:0]       fiu_rsp_tag,
  output logic [NUM_PORTS-1:0]              afu_rsp_valid,
  output logic [RSP_WIDTH-1:0]              afu_rsp_data,
  output logic [TAG_WIDTH-1:0]              afu_rsp_tag,
  output logic                              rsp_err,
  output logic [NUM_PORTS*32-1:0]           stat_grant_cnt
);

  logic                        out_valid_q, out_valid_d;
  logic [REQ_WIDTH-1:0]        out_data_q, out_data_d;
  logic [TAG_WIDTH+PIDX_W-1:0] out_tag_q, out_tag_d;
  logic [PIDX_W-1:0]           ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0]     credit_q, credit_d;
  logic [CNT_W-1:0]            outst_q [NUM_PORTS];
  logic [CNT_W-1:0]            outst_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]        rsp_valid_q, rsp_valid_d;
  logic [RSP_WIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0]        rsp_tag_q, rsp_tag_d;
  logic                        rsp_err_q, rsp_err_d;

  logic                        can_load_s;
  logic [NUM_PORTS-1:0]        elig_s;
  logic [NUM_PORTS-1:0]        grant_s;
  logic                        grant_valid_s;
  logic [PIDX_W-1:0]           grant_idx_s;
  logic [PIDX_W-1:0]           cand_s;
  logic [WEIGHT_WIDTH-1:0]     new_w_s;
  logic [PIDX_W-1:0]           rsp_idx_s;
  logic                        rsp_ok_s;

  // The output register may take a new request when empty or draining this cycle.
  assign can_load_s = !out_valid_q || fiu_req_ready;

  // A port is eligible when it has a request and room for one more in flight.
  always_comb begin
    elig_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig_s[p] = afu_req_valid[p] && (outst_q[p] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Weighted round-robin: stay on ptr while credit lasts, otherwise search
  // from ptr+1 with ptr checked last, and reload credit from the new weight.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    new_w_s       = '0;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    if (can_load_s) begin
      if (elig_s[ptr_q] && (credit_q != '0)) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = ptr_q;
        credit_d      = credit_q - WEIGHT_WIDTH'(1);
      end else begin
        for (int i = 1; i <= NUM_PORTS; i++) begin
          cand_s = PIDX_W'((int'(ptr_q) + i) % NUM_PORTS);
          if (!grant_valid_s && elig_s[cand_s]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = cand_s;
          end else begin
            grant_valid_s = grant_valid_s;
          end
        end
        if (grant_valid_s) begin
          new_w_s  = port_weight[int'(grant_idx_s)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          ptr_d    = grant_idx_s;
          credit_d = (new_w_s == '0) ? '0 : (new_w_s - WEIGHT_WIDTH'(1));
        end else begin
          ptr_d    = ptr_q;
          credit_d = credit_q;
        end
      end
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  // The one-hot grant doubles as the AFU ready.
  always_comb begin
    grant_s = '0;
    if (grant_valid_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end
  assign afu_req_ready = grant_s;

  // Output register: load on grant, empty on drain without grant, hold otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (can_load_s) begin
      out_valid_d = grant_valid_s;
      if (grant_valid_s) begin
        out_data_d = afu_req_data[int'(grant_idx_s)*REQ_WIDTH +: REQ_WIDTH];
        out_tag_d  = {grant_idx_s, afu_req_tag[int'(grant_idx_s)*TAG_WIDTH +: TAG_WIDTH]};
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Response decode: the upper tag bits select the destination port.
  assign rsp_idx_s = fiu_rsp_tag[TAG_WIDTH +: PIDX_W];
  assign rsp_ok_s  = fiu_rsp_valid && (int'(rsp_idx_s) < NUM_PORTS);

  // Response register and sticky out-of-range flag.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_ok_s) begin
      rsp_valid_d[rsp_idx_s] = 1'b1;
      rsp_data_d             = fiu_rsp_data;
      rsp_tag_d              = fiu_rsp_tag[TAG_WIDTH-1:0];
    end else if (fiu_rsp_valid) begin
      rsp_err_d = 1'b1;
    end else begin
      rsp_err_d = rsp_err_q;
    end
  end

  // Outstanding counters: +1 on grant, -1 on routed response (ignored at 0).
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      outst_d[p] = outst_q[p];
      if (grant_s[p] && !(rsp_ok_s && (int'(rsp_idx_s) == p) && (outst_q[p] != '0))) begin
        outst_d[p] = outst_q[p] + CNT_W'(1);
      end else if (!grant_s[p] && rsp_ok_s && (int'(rsp_idx_s) == p) && (outst_q[p] != '0)) begin
        outst_d[p] = outst_q[p] - CNT_W'(1);
      end else begin
        outst_d[p] = outst_q[p];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      ptr_q       <= '0;
      credit_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) outst_q[p] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      for (int p = 0; p < NUM_PORTS; p++) outst_q[p] <= outst_d[p];
    end
  end

  assign fiu_req_valid = out_valid_q;
  assign fiu_req_data  = out_data_q;
  assign fiu_req_tag   = out_tag_q;
  assign afu_rsp_valid = rsp_valid_q;
  assign afu_rsp_data  = rsp_data_q;
  assign afu_rsp_tag   = rsp_tag_q;
  assign rsp_err       = rsp_err_q;

`ifdef OFS_PLAT_HOST_CHAN_MUX_STATS_EN
  logic [31:0] stat_q [NUM_PORTS];
  logic [31:0] stat_d [NUM_PORTS];

  // Saturating per-port grant counters.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      stat_d[p] = stat_q[p];
      if (grant_s[p] && (stat_q[p] != 32'hFFFF_FFFF)) begin
        stat_d[p] = stat_q[p] + 32'd1;
      end else begin
        stat_d[p] = stat_q[p];
      end
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) stat_q[p] <= 32'd0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) stat_q[p] <= stat_d[p];
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_stat
    assign stat_grant_cnt[gp*32 +: 32] = stat_q[gp];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ofs_plat_host_chan_wrr_mux.sv
module tb_ofs_plat_host_chan_wrr_mux;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance A: 4 ports, deep outstanding limit ----------------
  logic [15:0]  a_weight;
  logic [3:0]   a_valid, a_ready;
  logic [63:0]  a_data, a_tag;
  logic         a_fv, a_frdy;
  logic [15:0]  a_fdata;
  logic [17:0]  a_ftag;
  logic         a_rv;
  logic [15:0]  a_rdata;
  logic [17:0]  a_rtag;
  logic [3:0]   a_arv;
  logic [15:0]  a_ardata, a_artag;
  logic         a_err;
  logic [127:0] a_stat;

  ofs_plat_host_chan_wrr_mux #(
    .NUM_PORTS(4), .REQ_WIDTH(16), .RSP_WIDTH(16), .TAG_WIDTH(16),
    .WEIGHT_WIDTH(4), .MAX_OUTSTANDING(64)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .port_weight(a_weight),
    .afu_req_valid(a_valid), .afu_req_ready(a_ready),
    .afu_req_data(a_data), .afu_req_tag(a_tag),
    .fiu_req_valid(a_fv), .fiu_req_ready(a_frdy),
    .fiu_req_data(a_fdata), .fiu_req_tag(a_ftag),
    .fiu_rsp_valid(a_rv), .fiu_rsp_data(a_rdata), .fiu_rsp_tag(a_rtag),
    .afu_rsp_valid(a_arv), .afu_rsp_data(a_ardata), .afu_rsp_tag(a_artag),
    .rsp_err(a_err), .stat_grant_cnt(a_stat)
  );

  // ---------------- instance B: 3 ports, limit of 2 in flight ----------------
  logic [11:0]  b_weight;
  logic [2:0]   b_valid, b_ready;
  logic [47:0]  b_data, b_tag;
  logic         b_fv, b_frdy;
  logic [15:0]  b_fdata;
  logic [17:0]  b_ftag;
  logic         b_rv;
  logic [15:0]  b_rdata;
  logic [17:0]  b_rtag;
  logic [2:0]   b_arv;
  logic [15:0]  b_ardata, b_artag;
  logic         b_err;
  logic [95:0]  b_stat;

  ofs_plat_host_chan_wrr_mux #(
    .NUM_PORTS(3), .REQ_WIDTH(16), .RSP_WIDTH(16), .TAG_WIDTH(16),
    .WEIGHT_WIDTH(4), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .port_weight(b_weight),
    .afu_req_valid(b_valid), .afu_req_ready(b_ready),
    .afu_req_data(b_data), .afu_req_tag(b_tag),
    .fiu_req_valid(b_fv), .fiu_req_ready(b_frdy),
    .fiu_req_data(b_fdata), .fiu_req_tag(b_ftag),
    .fiu_rsp_valid(b_rv), .fiu_rsp_data(b_rdata), .fiu_rsp_tag(b_rtag),
    .afu_rsp_valid(b_arv), .afu_rsp_data(b_ardata), .afu_rsp_tag(b_artag),
    .rsp_err(b_err), .stat_grant_cnt(b_stat)
  );

  typedef struct {
    bit          do_rst;
    logic [3:0]  valid;
    logic [15:0] weights;
    logic        fiu_rdy;
    logic [3:0]  exp_ready;
    logic        exp_fv;
    int          exp_port;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset both instances; returns at a falling edge with reset released.
  task automatic do_reset();
    a_valid = 4'd0;
    b_valid = 3'd0;
    a_rv    = 1'b0;
    b_rv    = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int wseq[14];
    logic [15:0] t16;
    wseq = '{1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3, 0, 0, 0};

    a_weight = 16'h0000; a_frdy = 1'b1; a_rdata = 16'h0000; a_rtag = 18'd0;
    b_weight = 12'h111;  b_frdy = 1'b1; b_rdata = 16'hCAFE; b_rtag = 18'd0;
    for (int p = 0; p < 4; p++) begin
      a_data[p*16 +: 16] = 16'hD000 + 16'(p);
      a_tag[p*16 +: 16]  = 16'h0100 + 16'(p);
    end
    for (int p = 0; p < 3; p++) begin
      b_data[p*16 +: 16] = 16'hB000 + 16'(p);
      b_tag[p*16 +: 16]  = 16'h0200 + 16'(p);
    end

    // ---- reset values ----
    do_reset();
    #1;
    chk("rst_a_fv", 128'(a_fv), 128'd0);
    chk("rst_a_fdata", 128'(a_fdata), 128'd0);
    chk("rst_a_ftag", 128'(a_ftag), 128'd0);
    chk("rst_a_arv", 128'(a_arv), 128'd0);
    chk("rst_a_err", 128'(a_err), 128'd0);
    chk("rst_a_stat", a_stat, 128'd0);
    chk("rst_b_fv", 128'(b_fv), 128'd0);
    chk("rst_b_err", 128'(b_err), 128'd0);
    @(negedge clk);

    // ---- table: weights {3,1,2,1}; first search starts at ptr+1 = port 1 ----
    for (int i = 0; i < 14; i++) begin
      vecs.push_back('{do_rst: (i == 0), valid: 4'hF, weights: 16'h1213, fiu_rdy: 1'b1,
                       exp_ready: 4'(4'd1 << wseq[i]), exp_fv: (i > 0),
                       exp_port: (i > 0) ? wseq[i-1] : 0});
    end
    // ---- table: only port 2, weight 0 -> granted every cycle ----
    for (int i = 0; i < 6; i++) begin
      vecs.push_back('{do_rst: (i == 0), valid: 4'b0100, weights: 16'h0000, fiu_rdy: 1'b1,
                       exp_ready: 4'b0100, exp_fv: (i > 0), exp_port: 2});
    end
    vecs.push_back('{do_rst: 1'b0, valid: 4'b0000, weights: 16'h0000, fiu_rdy: 1'b1,
                     exp_ready: 4'b0000, exp_fv: 1'b1, exp_port: 2});
    vecs.push_back('{do_rst: 1'b0, valid: 4'b0000, weights: 16'h0000, fiu_rdy: 1'b1,
                     exp_ready: 4'b0000, exp_fv: 1'b0, exp_port: 0});

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      a_valid  = vecs[i].valid;
      a_weight = vecs[i].weights;
      a_frdy   = vecs[i].fiu_rdy;
      #1;
      chk($sformatf("v%0d_ready", i), 128'(a_ready), 128'(vecs[i].exp_ready));
      chk($sformatf("v%0d_fv", i), 128'(a_fv), 128'(vecs[i].exp_fv));
      if (vecs[i].exp_fv) begin
        t16 = 16'h0100 + 16'(vecs[i].exp_port);
        chk($sformatf("v%0d_ftag", i), 128'(a_ftag), 128'({2'(vecs[i].exp_port), t16}));
        chk($sformatf("v%0d_fdata", i), 128'(a_fdata), 128'(16'hD000 + 16'(vecs[i].exp_port)));
      end
      @(negedge clk);
    end

    // ---- backpressure: output full, fiu_req_ready low for 5 cycles ----
    do_reset();
    a_valid = 4'hF; a_weight = 16'h1213; a_frdy = 1'b1;
    #1;
    chk("bp_first_grant", 128'(a_ready), 128'(4'b0010));
    @(negedge clk);
    a_frdy = 1'b0;
    a_data[16 +: 16] = 16'hEEEE;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), 128'(a_ready), 128'd0);
      chk($sformatf("bp%0d_fv", c), 128'(a_fv), 128'd1);
      chk($sformatf("bp%0d_ftag", c), 128'(a_ftag), 128'({2'd1, 16'h0101}));
      chk($sformatf("bp%0d_fdata", c), 128'(a_fdata), 128'(16'hD001));
      @(negedge clk);
    end
    a_frdy = 1'b1;
    a_data[16 +: 16] = 16'hD001;
    #1;
    chk("bp_resume_ready", 128'(a_ready), 128'(4'b0100));
    @(negedge clk);
    a_valid = 4'd0;
    #1;
    chk("bp_after_ftag", 128'(a_ftag), 128'({2'd2, 16'h0102}));
`ifdef OFS_PLAT_HOST_CHAN_MUX_STATS_EN
    chk("stat_a", a_stat, {32'd0, 32'd1, 32'd1, 32'd0});
`else
    chk("stat_a", a_stat, 128'd0);
`endif
    @(negedge clk);

    // ---- outstanding limit of 2 on port 1 (instance B) ----
    do_reset();
    b_valid = 3'b010; b_weight = 12'h111; b_frdy = 1'b1;
    #1; chk("ob_c0_ready", 128'(b_ready), 128'(3'b010)); @(negedge clk);
    #1; chk("ob_c1_ready", 128'(b_ready), 128'(3'b010)); @(negedge clk);
    #1; chk("ob_c2_blocked", 128'(b_ready), 128'd0);
        chk("ob_c2_ftag", 128'(b_ftag), 128'({2'd1, 16'h0201})); @(negedge clk);
    b_rv = 1'b1; b_rtag = {2'd1, 16'h00AB};
    #1; chk("ob_c3_blocked", 128'(b_ready), 128'd0); @(negedge clk);
    // count now 1: grant and response in the same cycle keep it at 1
    b_rv = 1'b1; b_rtag = {2'd1, 16'h0077};
    #1; chk("ob_c4_arv", 128'(b_arv), 128'(3'b010));
        chk("ob_c4_atag", 128'(b_artag), 128'(16'h00AB));
        chk("ob_c4_adata", 128'(b_ardata), 128'(16'hCAFE));
        chk("ob_c4_ready", 128'(b_ready), 128'(3'b010)); @(negedge clk);
    b_rv = 1'b0;
    #1; chk("ob_c5_arv", 128'(b_arv), 128'(3'b010));
        chk("ob_c5_atag", 128'(b_artag), 128'(16'h0077));
        chk("ob_c5_ready", 128'(b_ready), 128'(3'b010)); @(negedge clk);
    #1; chk("ob_c6_blocked", 128'(b_ready), 128'd0);
        chk("ob_c6_arv", 128'(b_arv), 128'd0); @(negedge clk);

    // ---- out-of-range response index 3 with NUM_PORTS=3 ----
    b_valid = 3'd0;
    b_rv = 1'b1; b_rtag = {2'd3, 16'h0055};
    #1; chk("err_pre", 128'(b_err), 128'd0); @(negedge clk);
    b_rv = 1'b0;
    #1; chk("err_arv", 128'(b_arv), 128'd0);
        chk("err_set", 128'(b_err), 128'd1);
    for (int c = 0; c < 3; c++) @(negedge clk);
    #1; chk("err_sticky", 128'(b_err), 128'd1);
    do_reset();
    #1; chk("err_cleared", 128'(b_err), 128'd0);
        chk("stat_b", b_stat, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
